// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared front-end types and constants for the fetch PC sequencer.
// Holds the sequencer state enum, the next-PC source encoding, the default
// reset PC and fetch-group size, and the sequential-advance helper.
package frontend_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_seq_state_t;

    // Encoding matches the redirect_src output: 0 seq, 1 nlp, 2 if3, 3 backend
    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_NLP = 2'd1,
        SRC_IF3 = 2'd2,
        SRC_BE  = 2'd3
    } redirect_src_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;
    localparam int unsigned FETCH_GROUP_BYTES = 8;

    // Start of the next aligned fetch group; a mid-group PC advances by less
    // than a full group. Arithmetic wraps at 32 bits.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc,
                                                input logic [31:0] group_bytes);
        return (pc & ~(group_bytes - 32'd1)) + group_bytes;
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the fetch sequencer.
// Priority: live backend > pending backend > live IF3 > pending IF3 >
// NLP taken (only on an accepted request) > sequential (only on accept).
// take_flush is raised only for a live redirect; a pending redirect already
// flushed IF1/IF2 when it was captured.
module fetch_next_pc
    import frontend_pkg::*;
#(
    parameter int unsigned FETCH_BYTES = FETCH_GROUP_BYTES
) (
    input  logic [31:0]   i_pc,
    input  logic          i_be_redirect,
    input  logic [31:0]   i_be_target,
    input  logic          i_if3_redirect,
    input  logic [31:0]   i_if3_target,
    input  logic          i_pend_valid,
    input  redirect_src_t i_pend_src,
    input  logic [31:0]   i_pend_target,
    input  logic          i_nlp_taken,
    input  logic [31:0]   i_nlp_target,
    input  logic          i_accept,
    output logic [31:0]   o_next_pc,
    output redirect_src_t o_src,
    output logic          o_take_flush
);

    logic [31:0] w_seq_pc;

    assign w_seq_pc = seq_next_pc(i_pc, 32'(FETCH_BYTES));

    // Priority mux over redirect sources, then accept-gated NLP/sequential
    always_comb begin
        o_next_pc    = i_pc;
        o_src        = SRC_SEQ;
        o_take_flush = 1'b0;
        if (i_be_redirect) begin
            o_next_pc    = i_be_target;
            o_src        = SRC_BE;
            o_take_flush = 1'b1;
        end else if (i_pend_valid && (i_pend_src == SRC_BE)) begin
            o_next_pc = i_pend_target;
            o_src     = SRC_BE;
        end else if (i_if3_redirect) begin
            o_next_pc    = i_if3_target;
            o_src        = SRC_IF3;
            o_take_flush = 1'b1;
        end else if (i_pend_valid) begin
            o_next_pc = i_pend_target;
            o_src     = i_pend_src;
        end else if (i_accept) begin
            if (i_nlp_taken) begin
                o_next_pc = i_nlp_target;
                o_src     = SRC_NLP;
            end else begin
                o_next_pc = w_seq_pc;
                o_src     = SRC_SEQ;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC and drives the ICache request.
// BOOT spends one idle cycle, RUN issues req_pc=pc, HOLD parks while paused
// and captures redirects in a one-entry pending register so none are lost.
// flush_if12 and redirect_src are registered: they describe the PC that is
// presented on req_pc in the same cycle.
// Optional: define FETCH_SEQ_PERF_EN to add saturating perf counters on
// perf_cnt = {nlp, if3, be, acc}.
module fetch_pc_sequencer
    import frontend_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned FETCH_BYTES = FETCH_GROUP_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             be_redirect,
    input  logic [31:0]      be_target,
    input  logic             if3_redirect,
    input  logic [31:0]      if3_target,
    input  logic             nlp_taken,
    input  logic [31:0]      nlp_target,
    input  logic             req_ready,
    output logic             req_valid,
    output logic [31:0]      req_pc,
    output logic             flush_if12,
    output logic [1:0]       redirect_src,
    output fetch_seq_state_t o_dbg_state
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [127:0]     perf_cnt
`endif
);

    fetch_seq_state_t r_state;
    logic [31:0]      r_pc;
    logic             r_pend_valid;
    logic [31:0]      r_pend_target;
    redirect_src_t    r_pend_src;
    logic             r_flush;
    redirect_src_t    r_src;

    logic             w_req_valid;
    logic             w_accept;
    logic             w_apply;
    logic             w_latch_if3;
    logic [31:0]      w_next_pc;
    redirect_src_t    w_src;
    logic             w_take_flush;

    // Handshake: a request transfers when req_valid && req_ready in the same
    // cycle; req_valid drops combinationally with pause and may be retargeted
    // by a redirect before it is accepted.
    assign w_req_valid = (r_state == RUN) && !pause;
    assign w_accept    = w_req_valid && req_ready;
    // BOOT always moves on; RUN/HOLD only update the PC when not paused
    assign w_apply     = (r_state == BOOT) || !pause;
    // IF3 never displaces a captured backend redirect
    assign w_latch_if3 = if3_redirect && !(r_pend_valid && (r_pend_src == SRC_BE));

    fetch_next_pc #(
        .FETCH_BYTES (FETCH_BYTES)
    ) u_next_pc (
        .i_pc           (r_pc),
        .i_be_redirect  (be_redirect),
        .i_be_target    (be_target),
        .i_if3_redirect (if3_redirect),
        .i_if3_target   (if3_target),
        .i_pend_valid   (r_pend_valid),
        .i_pend_src     (r_pend_src),
        .i_pend_target  (r_pend_target),
        .i_nlp_taken    (nlp_taken),
        .i_nlp_target   (nlp_target),
        .i_accept       (w_accept),
        .o_next_pc      (w_next_pc),
        .o_src          (w_src),
        .o_take_flush   (w_take_flush)
    );

    // Sequencer FSM with PC, pending-redirect capture and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_pend_src    <= SRC_SEQ;
            r_flush       <= 1'b0;
            r_src         <= SRC_SEQ;
        end else begin
            r_flush <= 1'b0;
            r_src   <= SRC_SEQ;
            case (r_state)
                BOOT:    r_state <= RUN;
                RUN:     if (pause) r_state <= HOLD;
                HOLD:    if (!pause) r_state <= RUN;
                default: r_state <= BOOT;
            endcase
            if (w_apply) begin
                r_pc         <= w_next_pc;
                r_flush      <= w_take_flush;
                r_src        <= w_src;
                r_pend_valid <= 1'b0;
            end else if (be_redirect) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= be_target;
                r_pend_src    <= SRC_BE;
                r_flush       <= 1'b1;
            end else if (w_latch_if3) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= if3_target;
                r_pend_src    <= SRC_IF3;
                r_flush       <= 1'b1;
            end
        end
    end

    assign req_valid    = w_req_valid;
    assign req_pc       = r_pc;
    assign flush_if12   = r_flush;
    assign redirect_src = r_src;
    assign o_dbg_state  = r_state;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] r_cnt_acc;
    logic [31:0] r_cnt_be;
    logic [31:0] r_cnt_if3;
    logic [31:0] r_cnt_nlp;

    // Saturating event counters for accepted requests and applied redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_acc <= 32'd0;
            r_cnt_be  <= 32'd0;
            r_cnt_if3 <= 32'd0;
            r_cnt_nlp <= 32'd0;
        end else begin
            if (w_accept && (r_cnt_acc != 32'hFFFF_FFFF))
                r_cnt_acc <= r_cnt_acc + 32'd1;
            if (w_apply && (w_src == SRC_BE) && (r_cnt_be != 32'hFFFF_FFFF))
                r_cnt_be <= r_cnt_be + 32'd1;
            if (w_apply && (w_src == SRC_IF3) && (r_cnt_if3 != 32'hFFFF_FFFF))
                r_cnt_if3 <= r_cnt_if3 + 32'd1;
            if (w_apply && (w_src == SRC_NLP) && (r_cnt_nlp != 32'hFFFF_FFFF))
                r_cnt_nlp <= r_cnt_nlp + 32'd1;
        end
    end

    assign perf_cnt = {r_cnt_nlp, r_cnt_if3, r_cnt_be, r_cnt_acc};
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Testbench for fetch_pc_sequencer: directed scenarios plus a randomized run,
// all checked against a behavioural model of the next-PC rules.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic        be_redirect = 1'b0;
    logic [31:0] be_target = 32'd0;
    logic        if3_redirect = 1'b0;
    logic [31:0] if3_target = 32'd0;
    logic        nlp_taken = 1'b0;
    logic [31:0] nlp_target = 32'd0;
    logic        req_ready = 1'b0;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        flush_if12;
    logic [1:0]  redirect_src;
    frontend_pkg::fetch_seq_state_t dbg_state;
`ifdef FETCH_SEQ_PERF_EN
    logic [127:0] perf_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .be_redirect  (be_redirect),
        .be_target    (be_target),
        .if3_redirect (if3_redirect),
        .if3_target   (if3_target),
        .nlp_taken    (nlp_taken),
        .nlp_target   (nlp_target),
        .req_ready    (req_ready),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .flush_if12   (flush_if12),
        .redirect_src (redirect_src),
        .o_dbg_state  (dbg_state)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_cnt     (perf_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = idle first cycle after reset, 1 = issuing, 2 = parked
    typedef struct {
        int          src;
        logic [31:0] tgt;
    } pend_t;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    int          m_phase, n_phase;
    logic [31:0] m_pc, n_pc;
    logic        m_flush, n_flush;
    int          m_src, n_src;
    pend_t       m_pend_q[$];
    pend_t       n_pend_q[$];

    task automatic reset_model();
        m_phase = 0;
        m_pc    = RST_PC;
        m_flush = 1'b0;
        m_src   = 0;
        m_pend_q.delete();
    endtask

    // Rank the candidate redirects numerically and take the highest;
    // otherwise an accepted request advances by NLP or to the next group.
    task automatic model_step();
        int          best;
        logic [31:0] tgt;
        n_phase  = m_phase;
        n_pc     = m_pc;
        n_flush  = 1'b0;
        n_src    = 0;
        n_pend_q = m_pend_q;
        tgt      = 32'd0;
        if (!rst) begin
            n_phase = 0;
            n_pc    = RST_PC;
            n_pend_q.delete();
        end else if (m_phase == 0 || !pause) begin
            best = 0;
            if (m_pend_q.size() > 0) begin
                best = (m_pend_q[0].src == 3) ? 3 : 1;
                tgt  = m_pend_q[0].tgt;
            end
            if (if3_redirect && best < 2) begin
                best = 2;
                tgt  = if3_target;
            end
            if (be_redirect) begin
                best = 4;
                tgt  = be_target;
            end
            if (best > 0) begin
                n_pc    = tgt;
                n_src   = (best >= 3) ? 3 : 2;
                n_flush = (best % 2 == 0);
            end else if (m_phase == 1 && req_ready) begin
                if (nlp_taken) begin
                    n_pc  = nlp_target;
                    n_src = 1;
                end else begin
                    n_pc = m_pc - (m_pc % 8) + 32'd8;
                end
            end
            n_pend_q.delete();
            n_phase = 1;
        end else begin
            n_phase = 2;
            if (be_redirect) begin
                n_pend_q.delete();
                n_pend_q.push_back('{src: 3, tgt: be_target});
                n_flush = 1'b1;
            end else if (if3_redirect && !(m_pend_q.size() > 0 && m_pend_q[0].src == 3)) begin
                n_pend_q.delete();
                n_pend_q.push_back('{src: 2, tgt: if3_target});
                n_flush = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        m_phase  = n_phase;
        m_pc     = n_pc;
        m_flush  = n_flush;
        m_src    = n_src;
        m_pend_q = n_pend_q;
    endtask

    task automatic clear_inputs();
        pause        = 1'b0;
        be_redirect  = 1'b0;
        if3_redirect = 1'b0;
        nlp_taken    = 1'b0;
        req_ready    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_model();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", req_valid); end
        n_vec++; if (req_pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", req_pc, RST_PC); end
        n_vec++; if (flush_if12 !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush_if12); end
        n_vec++; if (redirect_src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", redirect_src); end
        n_vec++; if (dbg_state !== frontend_pkg::BOOT) begin n_err++; $display("FAIL reset_state: got %0d want BOOT", dbg_state); end
        rst = 1'b1;
        req_ready = 1'b1;
        #1;
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", req_valid); end
        tick();
        n_vec++; if (req_valid !== 1'b1 || req_pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL first_req: got v=%b pc=%h want v=1 pc=bfc00000", req_valid, req_pc); end
        tick();
        n_vec++; if (req_pc !== 32'hBFC0_0008) begin n_err++; $display("FAIL seq_1: got %h want bfc00008", req_pc); end
        tick();
        n_vec++; if (req_pc !== 32'hBFC0_0010 || req_pc !== m_pc) begin n_err++; $display("FAIL seq_2: got %h want bfc00010", req_pc); end
    endtask

    task automatic test_misaligned();
        clear_inputs();
        if3_redirect = 1'b1; if3_target = 32'h8000_0004;
        tick();
        clear_inputs();
        #1;
        n_vec++; if (req_pc !== 32'h8000_0004 || flush_if12 !== 1'b1 || redirect_src !== 2'd2) begin n_err++; $display("FAIL if3_redirect: got pc=%h fl=%b src=%0d want 80000004/1/2", req_pc, flush_if12, redirect_src); end
        req_ready = 1'b1;
        tick();
        n_vec++; if (req_pc !== 32'h8000_0008 || req_pc !== m_pc) begin n_err++; $display("FAIL mid_group_seq: got %h want 80000008", req_pc); end
        n_vec++; if (flush_if12 !== 1'b0 || redirect_src !== 2'd0) begin n_err++; $display("FAIL seq_src: got fl=%b src=%0d want 0/0", flush_if12, redirect_src); end
    endtask

    task automatic test_priority();
        clear_inputs();
        be_redirect = 1'b1;  be_target  = 32'h8000_1000;
        if3_redirect = 1'b1; if3_target = 32'h8000_2000;
        nlp_taken = 1'b1;    nlp_target = 32'h8000_9000;
        req_ready = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_vec++; if (req_pc !== 32'h8000_1000 || redirect_src !== 2'd3 || flush_if12 !== 1'b1) begin n_err++; $display("FAIL be_priority: got pc=%h src=%0d fl=%b want 80001000/3/1", req_pc, redirect_src, flush_if12); end
        tick();
        n_vec++; if (flush_if12 !== 1'b0 || req_pc !== 32'h8000_1000) begin n_err++; $display("FAIL flush_one_cycle: got fl=%b pc=%h want 0 80001000", flush_if12, req_pc); end
    endtask

    task automatic test_pause_capture();
        clear_inputs();
        for (int c = 1; c <= 5; c++) begin
            pause = 1'b1;
            be_redirect  = (c == 3);   be_target  = 32'h8000_4000;
            if3_redirect = (c == 2);   if3_target = 32'h8000_3000;
            req_ready = 1'b1;
            #1;
            n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL pause_valid c%0d: got %b want 0", c, req_valid); end
            tick();
            n_vec++; if (flush_if12 !== ((c == 2) || (c == 3)) || flush_if12 !== m_flush) begin n_err++; $display("FAIL pause_flush c%0d: got %b want %b", c, flush_if12, m_flush); end
        end
        clear_inputs();
        req_ready = 1'b1;
        tick();
        n_vec++; if (req_pc !== 32'h8000_4000 || redirect_src !== 2'd3 || req_valid !== 1'b1) begin n_err++; $display("FAIL release_pend: got pc=%h src=%0d v=%b want 80004000/3/1", req_pc, redirect_src, req_valid); end
        tick();
        n_vec++; if (req_pc !== 32'h8000_4008) begin n_err++; $display("FAIL after_release: got %h want 80004008", req_pc); end
    endtask

    task automatic test_nlp_stall();
        logic [31:0] held;
        clear_inputs();
        held = m_pc;
        nlp_taken = 1'b1; nlp_target = 32'h8000_7000;
        tick();
        n_vec++; if (req_pc !== held || redirect_src !== 2'd0) begin n_err++; $display("FAIL nlp_no_accept: got pc=%h src=%0d want %h/0", req_pc, redirect_src, held); end
        if3_redirect = 1'b1; if3_target = 32'h8000_5000; req_ready = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_vec++; if (req_pc !== 32'h8000_5000 || redirect_src !== 2'd2) begin n_err++; $display("FAIL if3_over_nlp: got pc=%h src=%0d want 80005000/2", req_pc, redirect_src); end
    endtask

    task automatic test_wrap();
        clear_inputs();
        be_redirect = 1'b1; be_target = 32'hFFFF_FFF8;
        tick();
        clear_inputs();
        req_ready = 1'b1;
        tick();
        n_vec++; if (req_pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap: got %h want 00000000", req_pc); end
    endtask

    task automatic test_reset_mid_hold();
        clear_inputs();
        pause = 1'b1;
        tick();
        be_redirect = 1'b1; be_target = 32'h8000_6000;
        tick();
        clear_inputs();
        pause = 1'b1;
        #2;
        rst = 1'b0;
        reset_model();
        #1;
        n_vec++; if (req_pc !== RST_PC || req_valid !== 1'b0 || flush_if12 !== 1'b0) begin n_err++; $display("FAIL async_reset: got pc=%h v=%b fl=%b want %h/0/0", req_pc, req_valid, flush_if12, RST_PC); end
        tick();
        rst = 1'b1;
        pause = 1'b0;
        tick();
        tick();
        n_vec++; if (req_pc !== RST_PC || req_valid !== 1'b1 || redirect_src !== 2'd0) begin n_err++; $display("FAIL pend_discarded: got pc=%h v=%b src=%0d want %h/1/0", req_pc, req_valid, redirect_src, RST_PC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pause        = ($urandom_range(0, 99) < 20);
            be_redirect  = ($urandom_range(0, 99) < 8);
            if3_redirect = ($urandom_range(0, 99) < 12);
            nlp_taken    = ($urandom_range(0, 99) < 30);
            req_ready    = ($urandom_range(0, 99) < 70);
            be_target    = $urandom;
            if3_target   = $urandom;
            nlp_target   = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                reset_model();
            end else begin
                rst = 1'b1;
            end
            #1;
            n_vec++; if (req_valid !== (rst && m_phase == 1 && !pause)) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", i, req_valid, (m_phase == 1 && !pause)); end
            n_vec++; if (req_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", i, req_pc, m_pc); end
            n_vec++; if (flush_if12 !== m_flush) begin n_err++; $display("FAIL rnd_flush @%0d: got %b want %b", i, flush_if12, m_flush); end
            n_vec++; if (redirect_src !== 2'(m_src)) begin n_err++; $display("FAIL rnd_src @%0d: got %0d want %0d", i, redirect_src, m_src); end
            tick();
        end
        rst = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_misaligned();
        test_priority();
        test_pause_capture();
        test_nlp_stall();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
